// File: rtl/mem_arbiter_2p.sv
// Two-port round-robin arbiter that serialises single-word read/write
// transactions from two requesters onto a single-port memory interface.
module mem_arbiter_2p #(
    parameter int AW     = 4,
    parameter int DW     = 16,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          rw0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          ack0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          rw1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          ack1,
    output logic [DW-1:0] rdata1,
    output logic          mem_en,
    output logic          mem_rd_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wr_data,
    input  logic [DW-1:0] mem_rd_data,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    localparam logic [2:0] CNT_LOAD = 3'(RD_LAT - 1);

    state_t        state, state_nx;
    logic          last_grant, last_grant_nx;
    logic          win, win_nx;
    logic [2:0]    cnt, cnt_nx;
    logic          grant1;

    logic          ack0_nx, ack1_nx;
    logic [DW-1:0] rdata0_nx, rdata1_nx;
    logic          mem_en_nx, mem_rd_wr_nx;
    logic [AW-1:0] mem_addr_nx;
    logic [DW-1:0] mem_wr_data_nx;
    logic          busy_nx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            win         <= 1'b0;
            cnt         <= '0;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            rdata0      <= '0;
            rdata1      <= '0;
            mem_en      <= 1'b0;
            mem_rd_wr   <= 1'b0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nx;
            last_grant  <= last_grant_nx;
            win         <= win_nx;
            cnt         <= cnt_nx;
            ack0        <= ack0_nx;
            ack1        <= ack1_nx;
            rdata0      <= rdata0_nx;
            rdata1      <= rdata1_nx;
            mem_en      <= mem_en_nx;
            mem_rd_wr   <= mem_rd_wr_nx;
            mem_addr    <= mem_addr_nx;
            mem_wr_data <= mem_wr_data_nx;
            busy        <= busy_nx;
        end
    end

    always_comb begin
        state_nx       = state;
        last_grant_nx  = last_grant;
        win_nx         = win;
        cnt_nx         = cnt;
        ack0_nx        = 1'b0;
        ack1_nx        = 1'b0;
        rdata0_nx      = rdata0;
        rdata1_nx      = rdata1;
        mem_en_nx      = mem_en;
        mem_rd_wr_nx   = mem_rd_wr;
        mem_addr_nx    = mem_addr;
        mem_wr_data_nx = mem_wr_data;
        grant1         = 1'b0;

        case (state)
            IDLE: begin
                // On a tie the port that did not win last time is served.
                grant1 = req1 && (!req0 || !last_grant);
                if (req0 || req1) begin
                    win_nx         = grant1;
                    last_grant_nx  = grant1;
                    mem_en_nx      = 1'b1;
                    mem_rd_wr_nx   = grant1 ? rw1    : rw0;
                    mem_addr_nx    = grant1 ? addr1  : addr0;
                    mem_wr_data_nx = grant1 ? wdata1 : wdata0;
                    state_nx       = ISSUE;
                end
            end
            ISSUE: begin
                mem_en_nx = 1'b0;
                cnt_nx    = CNT_LOAD;
                state_nx  = WAIT;
            end
            WAIT: begin
                if (cnt != '0) begin
                    cnt_nx = cnt - 3'd1;
                end else begin
                    state_nx = DONE;
                    if (win) begin
                        ack1_nx = 1'b1;
                        if (!mem_rd_wr) rdata1_nx = mem_rd_data;
                    end else begin
                        ack0_nx = 1'b1;
                        if (!mem_rd_wr) rdata0_nx = mem_rd_data;
                    end
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        busy_nx = (state_nx != IDLE);
    end

endmodule

// File: tb/tb_mem_arbiter_2p.sv
// Directed bench for mem_arbiter_2p: RD_LAT=1 instance plus an RD_LAT=3
// instance, each driving a small behavioural single-port memory.
module tb_mem_arbiter_2p;

    localparam int AW = 4;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;

    logic          req0 = 0, rw0 = 0, req1 = 0, rw1 = 0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          ack0, ack1, mem_en, mem_rd_wr, busy;
    logic [DW-1:0] rdata0, rdata1, mem_wr_data, mem_rd_data;
    logic [AW-1:0] mem_addr;

    logic          s_req0 = 0, s_rw0 = 0, s_req1 = 0, s_rw1 = 0;
    logic [AW-1:0] s_addr0 = '0, s_addr1 = '0;
    logic [DW-1:0] s_wdata0 = '0, s_wdata1 = '0;
    logic          s_ack0, s_ack1, s_mem_en, s_mem_rd_wr, s_busy;
    logic [DW-1:0] s_rdata0, s_rdata1, s_mem_wr_data, s_mem_rd_data;
    logic [AW-1:0] s_mem_addr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter_2p #(.AW(AW), .DW(DW), .RD_LAT(1)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .rw0(rw0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .rw1(rw1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
        .mem_en(mem_en), .mem_rd_wr(mem_rd_wr), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data), .busy(busy)
    );

    mem_arbiter_2p #(.AW(AW), .DW(DW), .RD_LAT(3)) dut3 (
        .clk(clk), .reset(reset),
        .req0(s_req0), .rw0(s_rw0), .addr0(s_addr0), .wdata0(s_wdata0), .ack0(s_ack0), .rdata0(s_rdata0),
        .req1(s_req1), .rw1(s_rw1), .addr1(s_addr1), .wdata1(s_wdata1), .ack1(s_ack1), .rdata1(s_rdata1),
        .mem_en(s_mem_en), .mem_rd_wr(s_mem_rd_wr), .mem_addr(s_mem_addr),
        .mem_wr_data(s_mem_wr_data), .mem_rd_data(s_mem_rd_data), .busy(s_busy)
    );

    // Memory models: read data appears RD_LAT-1 edges after the sampling edge.
    logic [DW-1:0] mem1 [16];
    logic [DW-1:0] mem3 [16];
    logic [DW-1:0] rd1 = '0;
    logic [DW-1:0] p0 = '0, p1 = '0, p2 = '0;

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem1[i] = '0;
            mem3[i] = '0;
        end
        mem3[6] = 16'hBEEF;
    end

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_rd_wr) mem1[mem_addr] <= mem_wr_data;
            else           rd1 <= mem1[mem_addr];
        end
        if (s_mem_en) begin
            if (s_mem_rd_wr) mem3[s_mem_addr] <= s_mem_wr_data;
            else             p0 <= mem3[s_mem_addr];
        end
        p1 <= p0;
        p2 <= p1;
    end

    assign mem_rd_data   = rd1;
    assign s_mem_rd_data = p2;

    int   cyc = 0;
    int   last_rise = -100;
    int   min_gap = 1000;
    logic prev_en = 1'b0;
    bit   gap_on = 1'b0;

    always @(posedge clk) begin
        cyc++;
        if (mem_en && !prev_en) begin
            if (gap_on && (cyc - last_rise) < min_gap) min_gap = cyc - last_rise;
            last_rise = cyc;
        end
        prev_en = mem_en;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ticks until the given port acks; reports ticks taken and any stray ack.
    task automatic wait_ack(input bit port, input int exp_k, input string tag);
        int k = 0;
        bit seen = 0;
        bit other = 0;
        for (int i = 1; i <= 30 && !seen; i++) begin
            tick();
            if (port ? ack0 : ack1) other = 1;
            if (port ? ack1 : ack0) begin
                seen = 1;
                k = i;
            end
        end
        check({tag, " ack seen"}, 32'(seen), 32'd1);
        check({tag, " latency"}, 32'(k), 32'(exp_k));
        check({tag, " stray ack"}, 32'(other), 32'd0);
    endtask

    logic [DW-1:0] wvals [4];

    initial begin
        wvals[0] = 16'h1111;
        wvals[1] = 16'h2222;
        wvals[2] = 16'h3333;
        wvals[3] = 16'h4444;

        // Reset state
        repeat (3) tick();
        check("rst ack0", 32'(ack0), 0);
        check("rst ack1", 32'(ack1), 0);
        check("rst mem_en", 32'(mem_en), 0);
        check("rst busy", 32'(busy), 0);
        check("rst rdata0", 32'(rdata0), 0);
        reset = 1'b1;
        tick();

        // Test 1: port 0 write addr 3 = ABCD
        req0 = 1; rw0 = 1; addr0 = 4'd3; wdata0 = 16'hABCD;
        tick();
        check("t1 mem_en", 32'(mem_en), 1);
        check("t1 mem_addr", 32'(mem_addr), 3);
        check("t1 mem_rd_wr", 32'(mem_rd_wr), 1);
        check("t1 mem_wr_data", 32'(mem_wr_data), 32'hABCD);
        check("t1 busy", 32'(busy), 1);
        tick();
        check("t1 mem_en pulse", 32'(mem_en), 0);
        check("t1 mem_addr held", 32'(mem_addr), 3);
        wait_ack(0, 1, "t1");
        req0 = 0;
        tick();
        check("t1 ack0 width", 32'(ack0), 0);
        check("t1 idle busy", 32'(busy), 0);
        check("t1 ack1 never", 32'(ack1), 0);

        // Test 2: port 1 reads addr 3
        req1 = 1; rw1 = 0; addr1 = 4'd3;
        tick();
        check("t2 mem_rd_wr", 32'(mem_rd_wr), 0);
        check("t2 mem_addr", 32'(mem_addr), 3);
        wait_ack(1, 2, "t2");
        req1 = 0;
        check("t2 rdata1", 32'(rdata1), 32'hABCD);
        check("t2 rdata0", 32'(rdata0), 0);
        tick();
        check("t2 ack1 width", 32'(ack1), 0);

        // Test 3: simultaneous request right after reset
        reset = 0;
        tick();
        reset = 1;
        req0 = 1; rw0 = 1; addr0 = 4'd1; wdata0 = 16'h70AD;
        req1 = 1; rw1 = 0; addr1 = 4'd1;
        wait_ack(0, 3, "t3 p0");
        req0 = 0;
        wait_ack(1, 4, "t3 p1");
        req1 = 0;
        check("t3 rdata1", 32'(rdata1), 32'h70AD);
        tick();

        // Test 4: continuous requests alternate 0,1,0,1,0,1
        gap_on = 1;
        req0 = 1; rw0 = 1; addr0 = 4'd8; wdata0 = wvals[0];
        req1 = 1; rw1 = 0; addr1 = 4'd8;
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) begin
                wait_ack(0, 3, "t4 p0");
                wdata0 = wvals[i/2 + 1];
            end else begin
                wait_ack(1, 3, "t4 p1");
                check("t4 rdata1", 32'(rdata1), 32'(wvals[i/2]));
                if (i == 5) begin
                    req0 = 0;
                    req1 = 0;
                end
            end
            tick();
            check("t4 ack width", 32'({ack0, ack1}), 0);
        end
        gap_on = 0;
        check("t4 en gap", 32'(min_gap >= 4), 1);
        check("t4 rdata0 kept", 32'(rdata0), 0);

        // Test 5: reset during WAIT
        req0 = 1; rw0 = 1; addr0 = 4'd9; wdata0 = 16'h5A5A;
        tick();
        tick();
        reset = 0;
        #1;
        check("t5 ack0", 32'(ack0), 0);
        check("t5 busy", 32'(busy), 0);
        check("t5 mem_en", 32'(mem_en), 0);
        check("t5 mem_rd_wr", 32'(mem_rd_wr), 0);
        check("t5 mem_addr", 32'(mem_addr), 0);
        check("t5 mem_wr_data", 32'(mem_wr_data), 0);
        check("t5 rdata1", 32'(rdata1), 0);
        req0 = 0;
        repeat (2) tick();
        reset = 1;
        begin
            int acks = 0;
            for (int i = 0; i < 5; i++) begin
                tick();
                if (ack0 || ack1) acks++;
            end
            check("t5 no ack after reset", 32'(acks), 0);
        end
        req0 = 1; rw0 = 1; addr0 = 4'd9; wdata0 = 16'h5A5A;
        req1 = 1; rw1 = 0; addr1 = 4'd9;
        wait_ack(0, 3, "t5 tie p0");
        req0 = 0;
        wait_ack(1, 4, "t5 p1");
        req1 = 0;
        check("t5 rdata1", 32'(rdata1), 32'h5A5A);
        tick();

        // Test 6: RD_LAT=3 read of preloaded address
        s_req0 = 1; s_rw0 = 0; s_addr0 = 4'd6;
        begin
            int k = 0;
            bit seen = 0;
            for (int i = 1; i <= 30 && !seen; i++) begin
                tick();
                if (s_ack0) begin
                    seen = 1;
                    k = i;
                end
            end
            check("t6 ack seen", 32'(seen), 1);
            check("t6 latency", 32'(k), 5);
        end
        s_req0 = 0;
        check("t6 rdata0", 32'(s_rdata0), 32'hBEEF);
        tick();
        check("t6 ack width", 32'(s_ack0), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter_2p.md
Name: mem_arbiter_2p

Overview:
Two-port round-robin arbiter and sequencer in front of single_port_memory.
Each requester issues single-word read/write transactions over a req/ack handshake.
The block serialises the transactions onto the memory's en/addr/wr_data/rd_wr interface and returns read data.
Sits between the two client blocks and the memory instance; the memory's own ports connect 1:1 to the mem_* ports below.

Parameters:
AW, 4, address width (matches memory depth of 16 words)
DW, 16, data width
RD_LAT, 1, clock edges from memory sampling en to rd_data valid; legal range 1..7

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
req0  input  1  port 0 request, held high until ack0
rw0  input  1  port 0 op: 1 = write, 0 = read (memory rd_wr encoding)
addr0  input  AW  port 0 address
wdata0  input  DW  port 0 write data
ack0  output  1  port 0 completion pulse, one cycle
rdata0  output  DW  port 0 read data, valid while ack0=1 for reads
req1/rw1/addr1/wdata1/ack1/rdata1  same as port 0, for port 1
mem_en  output  1  to memory en
mem_rd_wr  output  1  to memory rd_wr
mem_addr  output  AW  to memory addr
mem_wr_data  output  DW  to memory wr_data
mem_rd_data  input  DW  from memory rd_data
busy  output  1  high in any state other than IDLE

Behaviour:
- All outputs are registered. On reset low, outputs clear asynchronously:
  - ack0/1=0, rdata0/1=0
  - mem_en=0, mem_rd_wr=0, mem_addr=0, mem_wr_data=0, busy=0
  - state=IDLE, last_grant=1 (so port 0 wins the first tie), wait counter=0
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - No req: stay in IDLE.
  - One req: grant that port.
  - Both req: grant the port not equal to last_grant.
  - On grant: latch winner id, rw, addr, wdata; set mem_en=1 and drive mem_addr/mem_wr_data/mem_rd_wr from the latched values; update last_grant; go to ISSUE.
- ISSUE:
  - Memory samples en=1 at this edge.
  - Next: mem_en=0; load wait counter with RD_LAT-1; go to WAIT.
  - mem_addr, mem_wr_data, mem_rd_wr hold their values until the next grant.
- WAIT:
  - While counter>0: decrement.
  - At 0: go to DONE; assert ack of the winner; if op is a read, capture mem_rd_data into that port's rdata.
  - Writes use the same timing, giving uniform latency.
- DONE: ack high for exactly this cycle; next edge clears ack and returns to IDLE. req is not sampled in DONE.
- Latency: req sampled at edge E0 -> mem_en high E0..E1 -> ack high after edge E0+1+RD_LAT, for one cycle. One transaction per 3+RD_LAT cycles, minimum.
- Requester holds req, rw, addr, wdata stable until ack. It may keep req high after ack to issue the next transaction, which is re-arbitrated in IDLE.
- Fairness: with both ports requesting continuously, grants strictly alternate 0,1,0,1,...
- A lone requester is granted back-to-back with no penalty.
- rdata of the non-winning port and rdata of a write winner keep their previous value.
- Reset mid-transaction aborts it; no ack is issued. A write may or may not have reached memory, and the requester must reissue after reset.
- req dropped before ack: illegal; the arbiter completes the latched transaction and pulses ack regardless.
- The memory's error, err_clr and out_wr_data_en signals are outside this block's scope.

Test Plan:
1. Port 0 write addr 3 = 16'hABCD, port 1 idle -> mem_en one cycle with mem_addr=3, mem_rd_wr=1, mem_wr_data=ABCD; ack0 after edge E0+2 (RD_LAT=1); ack1 never.
2. Port 1 read addr 3 after test 1 -> mem_rd_wr=0; ack1 one cycle with rdata1=16'hABCD; rdata0 unchanged.
3. Both ports request in the same cycle after reset (port 0 writes addr 1 = 16'h70AD, port 1 reads addr 1) -> port 0 served first; port 1 then reads 16'h70AD.
4. Both ports hold req high for 6 transactions -> grant order 0,1,0,1,0,1; each ack exactly one cycle; no two mem_en pulses closer than 4 cycles.
5. Reset driven low while in WAIT -> all outputs 0 immediately; no ack after reset release; next tie is granted to port 0.
6. RD_LAT=3 build, read of a preloaded address -> ack exactly 4 edges after the grant edge; rdata equals the memory content.
